// File: rtl/l2_mem_port.sv
// ---------------------------------------------------------------------------
// l2_mem_port
//
// Line-transfer engine that sits on the L2 side of the L2-to-main-memory bus.
// It takes one line request from the L2 controller and moves the line as
// LINE_BEATS sequential 64-bit beats. Each beat is presented with its own
// rising mem_req and is completed by the memory's stb. The whole line is
// handed back, or consumed, in one request/done handshake.
//
// Beat sequence: IDLE -> REQ -> GAP -> REQ -> ... -> REQ -> DONE -> IDLE.
// GAP is a single bus-idle cycle between beats so every beat starts with a
// fresh request edge and the write driver is released before the memory can
// turn the bus around.
//
// Build option:
//   MEM_TIMEOUT_EN - when defined, a per-beat counter aborts the transfer
//                    after TIMEOUT_CYC REQ cycles without stb. The transfer
//                    then ends with done=1 and err=1. When undefined, REQ
//                    waits for stb indefinitely and err is constant 0.
//
// Parameters:
//   ADDR_W      byte-address width
//   LINE_BEATS  64-bit beats per line (power of two, 2..16)
//   TIMEOUT_CYC per-beat stb wait limit (MEM_TIMEOUT_EN builds only)
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset_n    synchronous active-low reset
//   req_valid  L2 requests a line transfer
//   req_ready  engine idle; the request is taken when valid and ready
//   req_we     1 = writeback, 0 = fill
//   req_addr   line address; offset bits inside the line are ignored
//   wr_line    writeback data, beat 0 in bits [63:0]; sampled at accept
//   rd_line    fill data, valid with done when err is low
//   done       one-cycle completion pulse
//   err        qualifies done: transfer aborted by timeout
//   busy       transfer in progress
//   mem_we     beat direction toward memory
//   mem_addr   byte address of the current beat
//   mem_data   shared bidirectional 64-bit data bus
//   mem_req    beat request toward memory
//   stb        memory strobe: current beat completed
// ---------------------------------------------------------------------------
module l2_mem_port #(
    parameter int ADDR_W      = 32,
    parameter int LINE_BEATS  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [64*LINE_BEATS-1:0] wr_line,
    output logic [64*LINE_BEATS-1:0] rd_line,
    output logic                     done,
    output logic                     err,
    output logic                     busy,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    inout  wire  [63:0]              mem_data,
    output logic                     mem_req,
    input  logic                     stb
);

    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int OFF_W  = $clog2(8 * LINE_BEATS);
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int DATA_W = 64 * LINE_BEATS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [LINE_W-1:0]   line_q,  line_d;
    logic                we_q,    we_d;
    logic [DATA_W-1:0]   wr_q,    wr_d;
    logic [DATA_W-1:0]   rd_q,    rd_d;
    logic                last_beat;
    logic [63:0]         wr_beat;

    // Offset bits of the request address select nothing: the line base is
    // always aligned, and the beat index is spliced in below.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^req_addr[OFF_W-1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign last_beat = (beat_q == BEAT_W'(LINE_BEATS - 1));

    // Select the outgoing write beat without a variable-width part-select.
    always_comb begin
        wr_beat = 64'h0;
        for (int b = 0; b < LINE_BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                wr_beat = wr_q[64*b +: 64];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        we_d    = we_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
`ifdef MEM_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    line_d  = req_addr[ADDR_W-1:OFF_W];
                    we_d    = req_we;
                    wr_d    = wr_line;
                    beat_d  = '0;
                    state_d = S_REQ;
`ifdef MEM_TIMEOUT_EN
                    tmo_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end

            S_REQ: begin
                if (stb) begin
                    if (!we_q) begin
                        for (int b = 0; b < LINE_BEATS; b++) begin
                            if (beat_q == BEAT_W'(b)) begin
                                rd_d[64*b +: 64] = mem_data;
                            end
                        end
                    end
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = S_GAP;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                // tmo_q counts completed stb-less REQ cycles of this beat;
                // the TIMEOUT_CYC-th such cycle ends the transfer.
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d   = tmo_q + TMO_W'(1);
                end
`endif
            end

            S_GAP: begin
                state_d = S_REQ;
`ifdef MEM_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
        end
    end

    // Writeback data is only ever read while a write beat is in REQ, which
    // always follows a fresh accept, so it needs no reset value.
    always_ff @(posedge clk) begin
        wr_q <= wr_d;
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = (state_q == S_DONE) && err_q;
`else
    assign err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign req_ready = (state_q == S_IDLE);
    assign busy      = !req_ready;
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req && we_q;
    assign done      = (state_q == S_DONE);
    assign rd_line   = rd_q;

    // Beat offsets sit inside the aligned line, so they can never carry into
    // the line-address bits.
    assign mem_addr  = {line_q, beat_q, 3'b000};

    // The driver is decoded straight from registered state, so it lets go of
    // the bus on the same edge that leaves REQ.
    assign mem_data  = mem_we ? wr_beat : 64'bz;

endmodule

// File: tb/tb_l2_mem_port.sv
module tb_l2_mem_port;

    localparam int AW  = 32;
    localparam int LB  = 4;
    localparam int TMO = 8;
    localparam int LW  = 64 * LB;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] wr_line;
    logic [LW-1:0] rd_line;
    logic          done;
    logic          err;
    logic          busy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    wire  [63:0]   mem_data;
    logic          mem_req;
    logic          stb;

    always #5 clk = ~clk;

    l2_mem_port #(
        .ADDR_W      (AW),
        .LINE_BEATS  (LB),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .wr_line   (wr_line),
        .rd_line   (rd_line),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_req   (mem_req),
        .stb       (stb)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int bus_viol = 0;
    bit mon_en = 1'b0;

    // ---------------- memory model ----------------
    logic [63:0] mem_model [logic [31:0]];
    logic [63:0] tb_rd_val = 64'h0;

    // Memory drives read data during a read beat and a parked 0 whenever the
    // engine must not be driving; it never drives during a write beat.
    assign mem_data = (mem_req && mem_we) ? 64'bz : (mem_req ? tb_rd_val : 64'h0);

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a, ~a};
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~32'(8 * LB - 1);
    endfunction

    int rsp_delay = 0;
    bit rand_dly  = 1'b0;
    int cur_dly   = 0;
    int hold_beat = -1;
    bit spur_en   = 1'b0;
    int wait_cnt  = 0;

    logic [31:0] log_addr[$];
    logic [63:0] log_data[$];
    logic        log_we[$];
    int          log_dly[$];

    // Responder: acts 2 time units after each rising edge.
    initial begin
        stb = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req === 1'b1) begin
                tb_rd_val = mem_rd(mem_addr);
                if (hold_beat >= 0 && int'(mem_addr[4:3]) == hold_beat) begin
                    stb = 1'b0;
                end else if (wait_cnt >= cur_dly) begin
                    stb = 1'b1;
                    log_addr.push_back(mem_addr);
                    log_we.push_back(mem_we);
                    log_data.push_back(mem_we ? mem_data : tb_rd_val);
                    log_dly.push_back(cur_dly);
                    if (mem_we) mem_model[mem_addr] = mem_data;
                    wait_cnt = 0;
                    cur_dly  = rand_dly ? int'($urandom_range(0, 3)) : rsp_delay;
                end else begin
                    stb = 1'b0;
                    wait_cnt++;
                end
            end else begin
                stb = spur_en;
                wait_cnt = 0;
            end
        end
    end

    // Bus monitor: engine must never drive outside a write beat.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!(mem_req && mem_we) && mem_data !== (mem_req ? tb_rd_val : 64'h0)) bus_viol++;
                if (!mem_req && mem_we) bus_viol++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int d, input bit rnd);
        rsp_delay = d;
        rand_dly  = rnd;
        cur_dly   = rnd ? int'($urandom_range(0, 3)) : d;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_we.delete();
        log_dly.delete();
    endtask

    // Issues one request and runs to done; cyc is the done cycle counted from
    // the accept edge (or -1 if done never came).
    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [LW-1:0] line,
                           output int cyc, output logic e);
        int guard;
        req_we    = we;
        req_addr  = addr;
        wr_line   = line;
        req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
        e = err;
        if (done !== 1'b1) cyc = -1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        wr_line   = '0;
        repeat (3) tick();
        n_cmp++;
        if ({req_ready, busy, mem_req, mem_we, done, err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got {rdy,busy,req,we,done,err}=%b want 100000",
                     {req_ready, busy, mem_req, mem_we, done, err});
        end
        n_cmp++;
        if (mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 00000000", mem_addr);
        end
        n_cmp++;
        if (rd_line !== '0) begin
            n_fail++;
            $display("FAIL reset_rd_line: got %h want 0", rd_line);
        end
        reset_n = 1'b1;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic test_fill_zero_wait();
        logic [63:0] exp_d [LB];
        int cyc;
        logic e;
        int v0;
        exp_d[0] = 64'h1111_1111_1111_1111;
        exp_d[1] = 64'h2222_2222_2222_2222;
        exp_d[2] = 64'h3333_3333_3333_3333;
        exp_d[3] = 64'h4444_4444_4444_4444;
        for (int k = 0; k < LB; k++) mem_model[32'h1220 + 32'(8 * k)] = exp_d[k];
        set_delay(0, 1'b0);
        clear_log();
        v0 = bus_viol;
        do_xfer(1'b0, 32'h0000_1234, rand_line(), cyc, e);
        n_cmp++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL fill_done_cycle: got %0d want 8", cyc);
        end
        n_cmp++;
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_err: got %b want 0", e);
        end
        n_cmp++;
        if (log_addr.size() != LB) begin
            n_fail++;
            $display("FAIL fill_beats: got %0d want %0d", log_addr.size(), LB);
        end else begin
            for (int k = 0; k < LB; k++) begin
                n_cmp++;
                if (log_addr[k] !== 32'h1220 + 32'(8 * k)) begin
                    n_fail++;
                    $display("FAIL fill_addr%0d: got %h want %h", k, log_addr[k], 32'h1220 + 32'(8 * k));
                end
            end
        end
        for (int k = 0; k < LB; k++) begin
            n_cmp++;
            if (rd_line[64*k +: 64] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL fill_rd_beat%0d: got %h want %h", k, rd_line[64*k +: 64], exp_d[k]);
            end
        end
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_after_done: got ready=%b done=%b want 1 0", req_ready, done);
        end
        n_cmp++;
        if (bus_viol != v0) begin
            n_fail++;
            $display("FAIL fill_bus: got %0d violations want 0", bus_viol - v0);
        end
    endtask

    task automatic test_writeback_delay();
        logic [LW-1:0] line;
        logic [LW-1:0] prev_rd;
        logic [31:0] base;
        int cyc;
        logic e;
        int v0;
        line    = rand_line();
        base    = 32'h4000_0040;
        prev_rd = rd_line;
        set_delay(3, 1'b0);
        clear_log();
        v0 = bus_viol;
        do_xfer(1'b1, base | 32'h0000_0017, line, cyc, e);
        n_cmp++;
        if (cyc != 20) begin
            n_fail++;
            $display("FAIL wb_done_cycle: got %0d want 20", cyc);
        end
        n_cmp++;
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_err: got %b want 0", e);
        end
        for (int k = 0; k < LB; k++) begin
            n_cmp++;
            if (mem_model[base + 32'(8 * k)] !== line[64*k +: 64]) begin
                n_fail++;
                $display("FAIL wb_mem%0d: got %h want %h", k, mem_model[base + 32'(8 * k)], line[64*k +: 64]);
            end
        end
        n_cmp++;
        if (log_we.size() != LB || log_we.sum() with (int'(item)) != LB) begin
            n_fail++;
            $display("FAIL wb_dir: got %0d write beats want %0d", log_we.sum() with (int'(item)), LB);
        end
        n_cmp++;
        if (rd_line !== prev_rd) begin
            n_fail++;
            $display("FAIL wb_rd_hold: got %h want %h", rd_line, prev_rd);
        end
        tick();
        n_cmp++;
        if (bus_viol != v0) begin
            n_fail++;
            $display("FAIL wb_bus: got %0d violations want 0", bus_viol - v0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_addr, b_addr;
        logic [LW-1:0] l2;
        logic [63:0] exp_d [LB];
        int cyc, ready_viol, guard;
        a_addr = 32'h0000_2468;
        b_addr = 32'h0000_9ABC;
        l2     = rand_line();
        for (int k = 0; k < LB; k++) exp_d[k] = mem_rd(line_base(a_addr) + 32'(8 * k));
        set_delay(0, 1'b0);
        clear_log();
        req_we    = 1'b0;
        req_addr  = a_addr;
        wr_line   = rand_line();
        req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        req_we   = 1'b1;
        req_addr = b_addr;
        wr_line  = l2;
        cyc = 1;
        ready_viol = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (req_ready !== 1'b0) ready_viol++;
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL b2b_first_done: got %0d want 8", cyc);
        end
        n_cmp++;
        if (ready_viol != 0) begin
            n_fail++;
            $display("FAIL b2b_busy_ready: got %0d ready cycles want 0", ready_viol);
        end
        tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_after_done: got %b want 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL b2b_second_done: got %0d want 8", cyc);
        end
        n_cmp++;
        if (log_addr.size() != 2 * LB) begin
            n_fail++;
            $display("FAIL b2b_beats: got %0d want %0d", log_addr.size(), 2 * LB);
        end else begin
            for (int k = 0; k < 2 * LB; k++) begin
                logic [31:0] ea;
                logic        ew;
                logic [63:0] ed;
                ea = (k < LB) ? line_base(a_addr) + 32'(8 * k) : line_base(b_addr) + 32'(8 * (k - LB));
                ew = (k >= LB);
                ed = (k < LB) ? exp_d[k] : l2[64*(k-LB) +: 64];
                n_cmp++;
                if (log_addr[k] !== ea || log_we[k] !== ew || log_data[k] !== ed) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got a=%h we=%b d=%h want a=%h we=%b d=%h",
                             k, log_addr[k], log_we[k], log_data[k], ea, ew, ed);
                end
            end
        end
        for (int k = 0; k < LB; k++) begin
            n_cmp++;
            if (rd_line[64*k +: 64] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL b2b_rd_beat%0d: got %h want %h", k, rd_line[64*k +: 64], exp_d[k]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] addr, addr2;
        logic [63:0] exp_d [LB];
        int cyc, done_cnt, guard, v0;
        logic e;
        addr  = 32'h0001_0040;
        addr2 = 32'h0002_00A8;
        set_delay(0, 1'b0);
        clear_log();
        v0 = bus_viol;
        req_we    = 1'b0;
        req_addr  = addr;
        req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== addr + 32'd16) begin
            n_fail++;
            $display("FAIL rst_mid_beat2: got req=%b addr=%h want 1 %h", mem_req, mem_addr, addr + 32'd16);
        end
        reset_n = 1'b0;
        tick();
        n_cmp++;
        if ({mem_req, mem_we, done, req_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: got {req,we,done,rdy}=%b want 0001", {mem_req, mem_we, done, req_ready});
        end
        n_cmp++;
        if (mem_addr !== 32'h0 || rd_line !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got addr=%h rd=%h want 0 0", mem_addr, rd_line);
        end
        reset_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: got %0d done cycles want 0", done_cnt);
        end
        for (int k = 0; k < LB; k++) exp_d[k] = mem_rd(line_base(addr2) + 32'(8 * k));
        clear_log();
        do_xfer(1'b0, addr2, rand_line(), cyc, e);
        n_cmp++;
        if (cyc != 8 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_recover: got cyc=%0d err=%b want 8 0", cyc, e);
        end
        for (int k = 0; k < LB; k++) begin
            n_cmp++;
            if (rd_line[64*k +: 64] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL rst_mid_rd%0d: got %h want %h", k, rd_line[64*k +: 64], exp_d[k]);
            end
        end
        tick();
        n_cmp++;
        if (bus_viol != v0) begin
            n_fail++;
            $display("FAIL rst_mid_bus: got %0d violations want 0", bus_viol - v0);
        end
    endtask

    task automatic test_spurious_stb();
        logic [LW-1:0] prev_rd;
        logic [31:0] addr;
        logic [63:0] exp_d [LB];
        int cyc, idle_bad;
        logic e;
        addr    = 32'h0000_3300;
        prev_rd = rd_line;
        set_delay(1, 1'b0);
        clear_log();
        spur_en   = 1'b1;
        req_valid = 1'b0;
        idle_bad  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_ready !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0) idle_bad++;
        end
        n_cmp++;
        if (idle_bad != 0 || rd_line !== prev_rd) begin
            n_fail++;
            $display("FAIL spur_idle: got %0d bad cycles, rd changed=%b want 0 0", idle_bad, rd_line !== prev_rd);
        end
        for (int k = 0; k < LB; k++) exp_d[k] = mem_rd(line_base(addr) + 32'(8 * k));
        do_xfer(1'b0, addr, rand_line(), cyc, e);
        spur_en = 1'b0;
        n_cmp++;
        if (cyc != 4 * 2 + LB) begin
            n_fail++;
            $display("FAIL spur_done_cycle: got %0d want %0d", cyc, 4 * 2 + LB);
        end
        for (int k = 0; k < LB; k++) begin
            n_cmp++;
            if (rd_line[64*k +: 64] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL spur_rd%0d: got %h want %h", k, rd_line[64*k +: 64], exp_d[k]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            logic          we;
            logic [31:0]   addr, base;
            logic [LW-1:0] line, prev_rd, exp_rd;
            int            cyc, exp_cyc, v0;
            logic          e;
            we      = 1'($urandom_range(0, 1));
            addr    = $urandom;
            base    = line_base(addr);
            line    = rand_line();
            prev_rd = rd_line;
            for (int k = 0; k < LB; k++) exp_rd[64*k +: 64] = mem_rd(base + 32'(8 * k));
            set_delay(0, 1'b1);
            clear_log();
            v0 = bus_viol;
            do_xfer(we, addr, line, cyc, e);
            n_cmp++;
            if (log_addr.size() != LB) begin
                n_fail++;
                $display("FAIL rnd%0d_beats: got %0d want %0d", t, log_addr.size(), LB);
            end else begin
                exp_cyc = 2 * LB;
                for (int k = 0; k < LB; k++) exp_cyc += log_dly[k];
                n_cmp++;
                if (cyc != exp_cyc || e !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_done: got cyc=%0d err=%b want %0d 0", t, cyc, e, exp_cyc);
                end
                for (int k = 0; k < LB; k++) begin
                    n_cmp++;
                    if (log_addr[k] !== base + 32'(8 * k) || log_we[k] !== we) begin
                        n_fail++;
                        $display("FAIL rnd%0d_beat%0d: got a=%h we=%b want a=%h we=%b",
                                 t, k, log_addr[k], log_we[k], base + 32'(8 * k), we);
                    end
                end
            end
            if (we) begin
                for (int k = 0; k < LB; k++) begin
                    n_cmp++;
                    if (mem_rd(base + 32'(8 * k)) !== line[64*k +: 64]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_wmem%0d: got %h want %h", t, k, mem_rd(base + 32'(8 * k)), line[64*k +: 64]);
                    end
                end
                n_cmp++;
                if (rd_line !== prev_rd) begin
                    n_fail++;
                    $display("FAIL rnd%0d_rd_hold: got %h want %h", t, rd_line, prev_rd);
                end
            end else begin
                n_cmp++;
                if (rd_line !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rnd%0d_rd: got %h want %h", t, rd_line, exp_rd);
                end
            end
            tick();
            n_cmp++;
            if (bus_viol != v0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_post: got viol=%0d ready=%b want 0 1", t, bus_viol - v0, req_ready);
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        logic e;
        set_delay(0, 1'b0);
        clear_log();
        hold_beat = 1;
        do_xfer(1'b0, 32'h0000_5500, rand_line(), cyc, e);
        n_cmp++;
        if (cyc != 3 + TMO || e !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_done: got cyc=%0d err=%b want %0d 1", cyc, e, 3 + TMO);
        end
        n_cmp++;
        if (mem_req !== 1'b0 || log_addr.size() != 1) begin
            n_fail++;
            $display("FAIL tmo_abort: got req=%b beats=%0d want 0 1", mem_req, log_addr.size());
        end
        tick();
        hold_beat = -1;
        n_cmp++;
        if (req_ready !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_ready: got ready=%b err=%b want 1 0", req_ready, err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_zero_wait();
        test_writeback_delay();
        test_back_to_back();
        test_reset_mid();
        test_spurious_stb();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
